// File: rtl/shared_reg_arbiter_pkg.sv
// rtl/shared_reg_arbiter_pkg.sv - shared state encoding and types for the shared register arbiter
package shared_reg_arbiter_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_GRANT = ST_GRANT
  } arb_state_e;

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// rtl/shared_reg_arbiter_rr_pick.sv - combinational round-robin winner search starting at Ptr
module rr_pick #(
  parameter int N    = 4,
  parameter int IDXW = 2
) (
  input  logic [N-1:0]    Req,
  input  logic [IDXW-1:0] Ptr,
  output logic [IDXW-1:0] Win,
  output logic            Any
);

  logic [2*N-1:0]  req_dbl;
  logic [2*N-1:0]  req_rot;
  logic [IDXW-1:0] off;
  logic [IDXW:0]   sum;

  // Rotating a doubled copy puts the requester at Ptr in bit 0, so the
  // lowest set bit of the low half is the distance from Ptr to the winner.
  assign req_dbl = {Req, Req};
  assign req_rot = req_dbl >> Ptr;
  assign Any     = |Req;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off = IDXW'(k);
      end
    end
  end

  always_comb begin
    sum = {1'b0, Ptr} + {1'b0, off};
    if (sum >= (IDXW + 1)'(N)) begin
      sum = sum - (IDXW + 1)'(N);
    end
    Win = sum[IDXW-1:0];
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter loading one shared register from N requesters
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [N-1:0]       Req,
  input  logic [N*WIDTH-1:0] Data,
  output logic [N-1:0]       Gnt,
  output logic [WIDTH-1:0]   Q,
  output logic [IDXW-1:0]    Owner,
  output logic               Wr,
  output logic               Busy
);

  arb_state_e      state;
  arb_state_e      state_nxt;
  logic [IDXW-1:0] ptr;
  logic [IDXW-1:0] ptr_nxt;
  logic [IDXW-1:0] win;
  logic            any_req;
  logic            load;
  logic [N-1:0]    gnt_nxt;
  logic [WIDTH-1:0] data_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign data_arr[g] = Data[g*WIDTH +: WIDTH];
  end

  rr_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_rr_pick (
    .Req (Req),
    .Ptr (ptr),
    .Win (win),
    .Any (any_req)
  );

  // Arbitration only happens from IDLE; GRANT is a fixed one-cycle slot.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    gnt_nxt   = '0;
    ptr_nxt   = ptr;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = S_GRANT;
          gnt_nxt   = N'(1) << win;
          ptr_nxt   = (win == IDXW'(N - 1)) ? '0 : win + IDXW'(1);
        end
      end
      S_GRANT: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      Gnt   <= '0;
      Wr    <= 1'b0;
      Q     <= '0;
      Owner <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      Gnt   <= gnt_nxt;
      Wr    <= load;
      if (load) begin
        Q     <= data_arr[win];
        Owner <= win;
      end
    end
  end

  assign Busy = (state == S_GRANT);

endmodule
